// File: rtl/cdr_phase_ctrl_if.sv
// Sampler-side bus of the CDR phase controller: the data/edge/data sample
// triple with its qualifiers going in, phase select, step pulses and lock
// status coming out. The override pair exists only when CDR_OVERRIDE_EN is
// defined.
interface cdr_phase_ctrl_if #(
    parameter int PH_W = 3
);
    logic            en;
    logic            valid;
    logic            Dn_1;
    logic            Pn;
    logic            Dn;
    logic [PH_W-1:0] ph_sel;
    logic            ph_up;
    logic            ph_dn;
    logic            locked;
`ifdef CDR_OVERRIDE_EN
    logic            ovr_en;
    logic [PH_W-1:0] ovr_ph;
`endif

`ifdef CDR_OVERRIDE_EN
    modport master (
        output en, valid, Dn_1, Pn, Dn, ovr_en, ovr_ph,
        input  ph_sel, ph_up, ph_dn, locked
    );

    modport slave (
        input  en, valid, Dn_1, Pn, Dn, ovr_en, ovr_ph,
        output ph_sel, ph_up, ph_dn, locked
    );
`else
    modport master (
        output en, valid, Dn_1, Pn, Dn,
        input  ph_sel, ph_up, ph_dn, locked
    );

    modport slave (
        input  en, valid, Dn_1, Pn, Dn,
        output ph_sel, ph_up, ph_dn, locked
    );
`endif
endinterface

// File: rtl/cdr_phase_ctrl.sv
// Bang-bang CDR phase controller. Each valid sample triple casts an
// early/late vote; votes are integrated in a saturating signed accumulator
// and the sampler phase select is stepped when the accumulator reaches
// +/-THRESH. After a step the loop ignores HOLD valid samples while the new
// phase settles. A lock counter reports stable tracking.
// Optional feature macro: CDR_OVERRIDE_EN (manual phase override inputs).
module cdr_phase_ctrl #(
    parameter int PH_W     = 3,
    parameter int PH_INIT  = 0,
    parameter int ACC_W    = 5,
    parameter int THRESH   = 8,
    parameter int HOLD     = 4,
    parameter int LOCK_CNT = 16
) (
    input logic             clk,
    input logic             rst,
    cdr_phase_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SETTLE
    } state_t;

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int LOCK_W = $clog2(LOCK_CNT + 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CNT);

    // With HOLD=0 there is nothing to settle, so a step goes straight back
    // to tracking.
    localparam state_t AFTER_STEP = (HOLD == 0) ? TRACK : SETTLE;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [LOCK_W-1:0]        lock_q, lock_d;
    logic [PH_W-1:0]          ph_sel_q, ph_sel_d;
    logic                     ph_up_q, ph_up_d;
    logic                     ph_dn_q, ph_dn_d;
    logic                     locked_q, locked_d;
`ifdef CDR_OVERRIDE_EN
    logic                     ovr_en_q;
`endif

    logic                     transition;
    logic                     up_vote;
    logic                     dn_vote;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     step_up;
    logic                     step_dn;
    logic [LOCK_W-1:0]        lock_inc;

    // Early/late decision from the sample triple: the edge sample agrees
    // with the old bit when the clock is early, with the new bit when late.
    assign transition = bus.valid && (bus.Dn_1 != bus.Dn);
    assign up_vote    = transition && (bus.Pn == bus.Dn_1);
    assign dn_vote    = transition && (bus.Pn == bus.Dn);

    // Candidate accumulator value for this sample, saturating at +/-ACC_MAX.
    always_comb begin
        acc_nxt = acc_q;
        if (up_vote && (acc_q != ACC_MAX)) begin
            acc_nxt = acc_q + ACC_W'(1);
        end else if (dn_vote && (acc_q != ACC_MIN)) begin
            acc_nxt = acc_q - ACC_W'(1);
        end
    end

    assign step_up  = up_vote && (acc_nxt == THR_P);
    assign step_dn  = dn_vote && (acc_nxt == THR_N);
    assign lock_inc = (lock_q == LOCK_MAX) ? lock_q : lock_q + LOCK_W'(1);

    // Next-state and registered-output logic for the loop FSM.
    always_comb begin
        // NOTE: every signal written here gets its default first so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        lock_d   = lock_q;
        ph_sel_d = ph_sel_q;
        ph_up_d  = 1'b0;
        ph_dn_d  = 1'b0;

        if (!bus.en) begin
            // Loop disabled: forget all loop history, keep the phase.
            state_d = IDLE;
            acc_d   = '0;
            hold_d  = '0;
            lock_d  = '0;
        end
`ifdef CDR_OVERRIDE_EN
        else if (bus.ovr_en) begin
            // Manual phase: the loop is open and its history is discarded.
            ph_sel_d = bus.ovr_ph;
            acc_d    = '0;
            hold_d   = '0;
            lock_d   = '0;
        end else if (ovr_en_q) begin
            // Loop closes again on a freshly forced phase: let it settle.
            state_d = AFTER_STEP;
            hold_d  = '0;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end

                TRACK: begin
                    if (step_up || step_dn) begin
                        state_d  = AFTER_STEP;
                        acc_d    = '0;
                        hold_d   = '0;
                        lock_d   = '0;
                        ph_up_d  = step_up;
                        ph_dn_d  = step_dn;
                        ph_sel_d = step_up ? ph_sel_q + PH_W'(1)
                                           : ph_sel_q - PH_W'(1);
                    end else if (bus.valid) begin
                        acc_d  = acc_nxt;
                        lock_d = lock_inc;
                    end
                end

                SETTLE: begin
                    if (HOLD == 0) begin
                        state_d = TRACK;
                    end else if (bus.valid) begin
                        lock_d = lock_inc;
                        if (hold_q == HOLD_LAST) begin
                            state_d = TRACK;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (lock_d == LOCK_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            hold_q   <= '0;
            lock_q   <= '0;
            ph_sel_q <= PH_W'(PH_INIT);
            ph_up_q  <= 1'b0;
            ph_dn_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            ph_sel_q <= ph_sel_d;
            ph_up_q  <= ph_up_d;
            ph_dn_q  <= ph_dn_d;
            locked_q <= locked_d;
        end
    end

`ifdef CDR_OVERRIDE_EN
    // Remember the previous override request to detect its falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_en_q <= 1'b0;
        end else begin
            ovr_en_q <= bus.ovr_en;
        end
    end
`endif

    assign bus.ph_sel = ph_sel_q;
    assign bus.ph_up  = ph_up_q;
    assign bus.ph_dn  = ph_dn_q;
    assign bus.locked = locked_q;

endmodule
